// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared state encoding and counter sizing for the hex display arbiter
package hex_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_OWN   = 2'd2
    } hd_state_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((longint'(1) << i) <= longint'(max_val)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick of the first request after the last owner
module rr_picker #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_last,
    output logic [NREQ-1:0] o_pick,
    output logic [1:0]      o_idx,
    output logic            o_valid
);

    // Ascending scan above the last owner first, then wrap to the low indices.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!o_valid && i_req[i] && (i > int'(i_last))) begin
                o_valid   = 1'b1;
                o_pick[i] = 1'b1;
                o_idx     = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!o_valid && i_req[i] && (i <= int'(i_last))) begin
                o_valid   = 1'b1;
                o_pick[i] = 1'b1;
                o_idx     = 2'(i);
            end
        end
    end

endmodule

// File: rtl/hex_disp_arbiter.sv
// rtl/hex_disp_arbiter.sv - round-robin owner arbitration with min hold and blanking for the hex display
module hex_disp_arbiter
    import hex_disp_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int DW        = 32,
    parameter int HOLD_CYC  = 50_000_000,
    parameter int BLANK_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data_in,
    output logic [NREQ-1:0]    grant,
    output logic [1:0]         owner_id,
    output logic [DW-1:0]      disp_data,
    output logic               disp_en
);

    localparam int HW = cnt_width(HOLD_CYC);
    localparam int BW = cnt_width(BLANK_CYC);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYC);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

    hd_state_t       r_state, w_state_nxt;
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic [BW-1:0]   r_blank, w_blank_nxt;
    logic [1:0]      r_last, w_last_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic [1:0]      r_owner, w_owner_nxt;
    logic [DW-1:0]   r_data, w_data_nxt;
    logic            r_en, w_en_nxt;

    logic [NREQ-1:0] w_pick;
    logic [1:0]      w_pick_idx;
    logic            w_pick_valid;
    logic            w_own_req;
    logic            w_other_req;

    rr_picker #(
        .NREQ (NREQ)
    ) u_rr_picker (
        .i_req   (req),
        .i_last  (r_last),
        .o_pick  (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_own_req   = |(req & r_grant);
    assign w_other_req = |(req & ~r_grant);

    // Outputs default to zero so every path that leaves OWN blanks the display on that edge.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_blank_nxt = r_blank;
        w_last_nxt  = r_last;
        w_grant_nxt = '0;
        w_owner_nxt = '0;
        w_data_nxt  = '0;
        w_en_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_BLANK;
                    w_blank_nxt = '0;
                end
            end
            ST_BLANK: begin
                if (r_blank == BLANK_LAST) begin
                    if (w_pick_valid) begin
                        w_state_nxt = ST_OWN;
                        w_grant_nxt = w_pick;
                        w_owner_nxt = w_pick_idx;
                        w_data_nxt  = data_in[int'(w_pick_idx)*DW +: DW];
                        w_en_nxt    = 1'b1;
                        w_last_nxt  = w_pick_idx;
                        w_hold_nxt  = HW'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_blank_nxt = r_blank + BW'(1);
                end
            end
            ST_OWN: begin
                // A drop wins over pre-emption; either way the next owner is chosen after blanking.
                if (!w_own_req || ((r_hold == HOLD_MAX) && w_other_req)) begin
                    w_state_nxt = w_other_req ? ST_BLANK : ST_IDLE;
                    w_blank_nxt = '0;
                end else begin
                    w_grant_nxt = r_grant;
                    w_owner_nxt = r_owner;
                    w_data_nxt  = data_in[int'(r_owner)*DW +: DW];
                    w_en_nxt    = 1'b1;
                    if (r_hold != HOLD_MAX) begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_blank <= '0;
            r_last  <= 2'(NREQ - 1);
            r_grant <= '0;
            r_owner <= '0;
            r_data  <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_blank <= w_blank_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_data  <= w_data_nxt;
            r_en    <= w_en_nxt;
        end
    end

    assign grant     = r_grant;
    assign owner_id  = r_owner;
    assign disp_data = r_data;
    assign disp_en   = r_en;

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// tb/tb_hex_disp_arbiter.sv - directed self-checking bench for hex_disp_arbiter
module tb_hex_disp_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 32;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [DW-1:0]   data0;
    logic [DW-1:0]   data1;
    logic [NREQ-1:0] grant;
    logic [1:0]      owner_id;
    logic [DW-1:0]   disp_data;
    logic            disp_en;

    int n_checks = 0;
    int n_errors = 0;

    hex_disp_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .HOLD_CYC  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   ({data1, data0}),
        .grant     (grant),
        .owner_id  (owner_id),
        .disp_data (disp_data),
        .disp_en   (disp_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_zero(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("zero_grant", 32'(grant), 32'd0);
            chk("zero_en", 32'(disp_en), 32'd0);
            chk("zero_data", disp_data, 32'd0);
            chk("zero_owner", 32'(owner_id), 32'd0);
        end
    endtask

    task automatic expect_own(input int n, input int idx, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("own_grant", 32'(grant), 32'(1) << idx);
            chk("own_id", 32'(owner_id), 32'(idx));
            chk("own_data", disp_data, d);
            chk("own_en", 32'(disp_en), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        chk("onehot", 32'($countones(grant) <= 1), 32'd1);
        chk("en_is_or_grant", 32'(disp_en), 32'(|grant));
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        data0 = '0;
        data1 = '0;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_en", 32'(disp_en), 32'd0);
        chk("rst_data", disp_data, 32'd0);
        rst_n = 1'b1;
        expect_zero(20);

        // Single requester, hold past the minimum, live data update
        req   = 2'b01;
        data0 = 32'h1234_5678;
        data1 = 32'hABCD_0001;
        expect_zero(2);
        expect_own(13, 0, 32'h1234_5678);
        data0 = 32'h0000_00FF;
        expect_own(1, 0, 32'h0000_00FF);
        data0 = 32'h1234_5678;
        expect_own(1, 0, 32'h1234_5678);
        req = 2'b00;
        expect_zero(4);

        // Early release lands in IDLE: re-request needs the full IDLE+blank path
        req = 2'b01;
        expect_zero(2);
        expect_own(3, 0, 32'h1234_5678);
        req = 2'b00;
        expect_zero(1);
        req = 2'b01;
        expect_zero(2);
        expect_own(1, 0, 32'h1234_5678);
        req = 2'b00;
        expect_zero(3);

        // Requester 1 alone, then asynchronous reset mid-ownership
        req = 2'b10;
        expect_zero(2);
        expect_own(2, 1, 32'hABCD_0001);
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_en", 32'(disp_en), 32'd0);
        chk("async_data", disp_data, 32'd0);
        chk("async_owner", 32'(owner_id), 32'd0);
        tick();
        tick();
        req   = 2'b11;
        rst_n = 1'b1;

        // Alternation with pointer reset: requester 0 first
        expect_zero(2);
        expect_own(8, 0, 32'h1234_5678);
        expect_zero(2);
        expect_own(8, 1, 32'hABCD_0001);
        expect_zero(2);
        expect_own(8, 0, 32'h1234_5678);

        // Requester 1 drops during blank and must not be granted
        expect_zero(1);
        req = 2'b01;
        expect_zero(1);
        expect_own(3, 0, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
